// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: execute-stage branch resolver that owns the fetch PC.
// Resolves relative, conditional, status-flag, absolute and call/return
// branches, keeps a circular return-address stack (RAS) and runs a fixed
// length flush sequence after every taken branch.
// Optional feature macro: BRANCH_COUNT_EN adds takenCount_o, a saturating
// count of taken branches.
module branch_resolve_unit #(
   parameter int PC_W         = 16,
   parameter int OPND_W       = 16,
   parameter int RAS_DEPTH    = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              enable_i,
   input  logic              isStalled_i,
   input  logic [6:0]        opCode_i,
   input  logic [OPND_W-1:0] pOperand_i,
   input  logic [OPND_W-1:0] sOperand_i,
   input  logic [PC_W-1:0]   pc_i,
   input  logic [1:0]        opStat_i,
   output logic [PC_W-1:0]   pc_o,
   output logic              flushBack_o,
   output logic              busy_o,
   output logic              rasFull_o,
   output logic              rasEmpty_o,
`ifdef BRANCH_COUNT_EN
   output logic [15:0]       takenCount_o,
`endif
   output logic              fault_o
);

   // ------------------------------------------------------------------
   // Derived sizes
   // ------------------------------------------------------------------
   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);
   localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   localparam logic [PC_W-1:0]  PC_ONE     = PC_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RAS_DEPTH);
   localparam logic [FC_W-1:0]  FC_ONE     = FC_W'(1);
   localparam logic [FC_W-1:0]  FC_ZERO    = FC_W'(0);
   localparam logic [FC_W-1:0]  FC_LAST    = FC_W'(FLUSH_CYCLES - 1);

   // Opcode encodings
   localparam logic [6:0] OP_BNZ_FWD  = 7'd1;
   localparam logic [6:0] OP_BR_FWD   = 7'd2;
   localparam logic [6:0] OP_BNZ_BWD  = 7'd3;
   localparam logic [6:0] OP_BR_BWD   = 7'd4;
   localparam logic [6:0] OP_BOV_FWD  = 7'd5;
   localparam logic [6:0] OP_BUN_FWD  = 7'd6;
   localparam logic [6:0] OP_BOV_BWD  = 7'd7;
   localparam logic [6:0] OP_BUN_BWD  = 7'd8;
   localparam logic [6:0] OP_CALL     = 7'd9;
   localparam logic [6:0] OP_RET      = 7'd10;
   localparam logic [6:0] OP_JMPA     = 7'd11;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   // Operand is zero-extended or truncated to the PC width.
   function automatic logic [PC_W-1:0] fit_operand(input logic [OPND_W-1:0] v);
      return PC_W'(v);
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_e           state_q,     state_d;
   logic [PC_W-1:0]  pc_q,        pc_d;
   logic             flush_q,     flush_d;
   logic             busy_q,      busy_d;
   logic             fault_q,     fault_d;
   logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic [PTR_W-1:0] top_q,       top_d;
   logic [CNT_W-1:0] count_q,     count_d;
   logic [PC_W-1:0]  ras_q [RAS_DEPTH];

   // ------------------------------------------------------------------
   // Combinational decode results
   // ------------------------------------------------------------------
   logic [PC_W-1:0]  offset_s;
   logic [PC_W-1:0]  pc_plus1_s;
   logic [PC_W-1:0]  ras_top_s;
   logic             ras_empty_s;
   logic             ras_full_s;
   logic             taken_s;
   logic [PC_W-1:0]  tgt_s;
   logic             push_s;
   logic             pop_s;
   logic             ret_empty_s;
   logic             ras_we_s;
   logic [PTR_W-1:0] ras_widx_s;

   assign offset_s    = fit_operand(pOperand_i);
   assign pc_plus1_s  = pc_i + PC_ONE;
   assign ras_top_s   = ras_q[top_q];
   assign ras_empty_s = (count_q == CNT_ZERO);
   assign ras_full_s  = (count_q == CNT_FULL);

   // Decode the opcode into taken/target and the RAS operation it requests.
   always_comb begin
      taken_s     = 1'b0;
      tgt_s       = pc_plus1_s;
      push_s      = 1'b0;
      pop_s       = 1'b0;
      ret_empty_s = 1'b0;
      case (opCode_i)
         OP_BNZ_FWD: begin
            taken_s = (sOperand_i != {OPND_W{1'b0}});
            tgt_s   = pc_i + offset_s;
         end
         OP_BR_FWD: begin
            taken_s = 1'b1;
            tgt_s   = pc_i + offset_s;
         end
         OP_BNZ_BWD: begin
            taken_s = (sOperand_i != {OPND_W{1'b0}});
            tgt_s   = pc_i - offset_s;
         end
         OP_BR_BWD: begin
            taken_s = 1'b1;
            tgt_s   = pc_i - offset_s;
         end
         OP_BOV_FWD: begin
            taken_s = opStat_i[1];
            tgt_s   = pc_i + offset_s;
         end
         OP_BUN_FWD: begin
            taken_s = opStat_i[0];
            tgt_s   = pc_i + offset_s;
         end
         OP_BOV_BWD: begin
            taken_s = opStat_i[1];
            tgt_s   = pc_i - offset_s;
         end
         OP_BUN_BWD: begin
            taken_s = opStat_i[0];
            tgt_s   = pc_i - offset_s;
         end
         OP_CALL: begin
            taken_s = 1'b1;
            tgt_s   = pc_i + offset_s;
            push_s  = 1'b1;
         end
         OP_RET: begin
            if (ras_empty_s) begin
               ret_empty_s = 1'b1;
            end else begin
               taken_s = 1'b1;
               tgt_s   = ras_top_s;
               pop_s   = 1'b1;
            end
         end
         OP_JMPA: begin
            taken_s = 1'b1;
            tgt_s   = offset_s;
         end
         default: begin
            taken_s = 1'b0;
            tgt_s   = pc_plus1_s;
         end
      endcase
   end

   // Next-state logic for the IDLE/FLUSH sequencer, fetch PC and RAS pointers.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      flush_d     = flush_q;
      busy_d      = busy_q;
      fault_d     = 1'b0;
      flush_cnt_d = flush_cnt_q;
      top_d       = top_q;
      count_d     = count_q;
      ras_we_s    = 1'b0;
      ras_widx_s  = top_q + PTR_ONE;
      case (state_q)
         ST_IDLE: begin
            if (isStalled_i) begin
               pc_d = pc_q;
            end else if (enable_i && taken_s) begin
               pc_d        = tgt_s;
               flush_d     = 1'b1;
               busy_d      = 1'b1;
               flush_cnt_d = FC_ZERO;
               state_d     = ST_FLUSH;
               if (push_s) begin
                  // A full stack silently drops its oldest entry.
                  ras_we_s = 1'b1;
                  top_d    = top_q + PTR_ONE;
                  count_d  = ras_full_s ? count_q : (count_q + CNT_ONE);
               end else if (pop_s) begin
                  top_d    = top_q - PTR_ONE;
                  count_d  = count_q - CNT_ONE;
               end else begin
                  top_d    = top_q;
               end
            end else begin
               pc_d    = pc_plus1_s;
               fault_d = enable_i & ret_empty_s;
            end
         end
         ST_FLUSH: begin
            // Younger ops are squashed: enable_i and isStalled_i are ignored.
            if (flush_cnt_q == FC_LAST) begin
               state_d     = ST_IDLE;
               flush_d     = 1'b0;
               busy_d      = 1'b0;
               flush_cnt_d = FC_ZERO;
            end else begin
               flush_cnt_d = flush_cnt_q + FC_ONE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            flush_d     = 1'b0;
            busy_d      = 1'b0;
            flush_cnt_d = FC_ZERO;
         end
      endcase
   end

   // Control and PC registers with synchronous reset.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         pc_q        <= {PC_W{1'b0}};
         flush_q     <= 1'b0;
         busy_q      <= 1'b0;
         fault_q     <= 1'b0;
         flush_cnt_q <= FC_ZERO;
         top_q       <= {PTR_W{1'b0}};
         count_q     <= CNT_ZERO;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         flush_q     <= flush_d;
         busy_q      <= busy_d;
         fault_q     <= fault_d;
         flush_cnt_q <= flush_cnt_d;
         top_q       <= top_d;
         count_q     <= count_d;
      end
   end

   // Return-address storage; one write per cycle at most.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_q[i] <= {PC_W{1'b0}};
         end
      end else if (ras_we_s) begin
         ras_q[ras_widx_s] <= pc_plus1_s;
      end
   end

`ifdef BRANCH_COUNT_EN
   logic [15:0] taken_cnt_q, taken_cnt_d;

   // Saturating count of IDLE->FLUSH transitions.
   always_comb begin
      taken_cnt_d = taken_cnt_q;
      if ((state_q == ST_IDLE) && (state_d == ST_FLUSH) && (taken_cnt_q != 16'hFFFF)) begin
         taken_cnt_d = taken_cnt_q + 16'd1;
      end else begin
         taken_cnt_d = taken_cnt_q;
      end
   end

   // Taken-branch counter register.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         taken_cnt_q <= 16'd0;
      end else begin
         taken_cnt_q <= taken_cnt_d;
      end
   end

   assign takenCount_o = taken_cnt_q;
`endif

   assign pc_o        = pc_q;
   assign flushBack_o = flush_q;
   assign busy_o      = busy_q;
   assign fault_o     = fault_q;
   assign rasFull_o   = ras_full_s;
   assign rasEmpty_o  = ras_empty_s;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by
// randomized traffic, all compared against a queue-based behavioural model.
module tb_branch_resolve_unit;

   localparam int FLUSH_N = 2;
   localparam int DEPTH   = 4;

   logic        clock_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        enable_i = 1'b0;
   logic        isStalled_i = 1'b0;
   logic [6:0]  opCode_i = 7'd0;
   logic [15:0] pOperand_i = 16'd0;
   logic [15:0] sOperand_i = 16'd0;
   logic [15:0] pc_i = 16'd0;
   logic [1:0]  opStat_i = 2'd0;
   logic [15:0] pc_o;
   logic        flushBack_o, busy_o, rasFull_o, rasEmpty_o, fault_o;
`ifdef BRANCH_COUNT_EN
   logic [15:0] takenCount_o;
`endif

   branch_resolve_unit #(
      .PC_W(16), .OPND_W(16), .RAS_DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_N)
   ) dut (
      .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
      .isStalled_i(isStalled_i), .opCode_i(opCode_i), .pOperand_i(pOperand_i),
      .sOperand_i(sOperand_i), .pc_i(pc_i), .opStat_i(opStat_i),
      .pc_o(pc_o), .flushBack_o(flushBack_o), .busy_o(busy_o),
      .rasFull_o(rasFull_o), .rasEmpty_o(rasEmpty_o),
`ifdef BRANCH_COUNT_EN
      .takenCount_o(takenCount_o),
`endif
      .fault_o(fault_o)
   );

   always #5 clock_i = ~clock_i;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   int          m_pc;
   int          m_left;
   bit          m_fault;
   int          m_taken;
   logic [15:0] m_ras[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock using the inputs in force at that edge.
   task automatic model_step();
      int tk;
      int tgt;
      int pcv;
      int off;
      pcv = int'(pc_i);
      off = int'(pOperand_i);
      if (reset_i) begin
         m_pc = 0; m_left = 0; m_fault = 0; m_taken = 0;
         m_ras.delete();
      end else begin
         m_fault = 0;
         if (m_left > 0) begin
            m_left = m_left - 1;
         end else if (!isStalled_i) begin
            tk  = 0;
            tgt = 0;
            if (enable_i) begin
               case (int'(opCode_i))
                  1: begin tk = (sOperand_i != 16'd0); tgt = pcv + off; end
                  2: begin tk = 1; tgt = pcv + off; end
                  3: begin tk = (sOperand_i != 16'd0); tgt = pcv - off; end
                  4: begin tk = 1; tgt = pcv - off; end
                  5: begin tk = opStat_i[1]; tgt = pcv + off; end
                  6: begin tk = opStat_i[0]; tgt = pcv + off; end
                  7: begin tk = opStat_i[1]; tgt = pcv - off; end
                  8: begin tk = opStat_i[0]; tgt = pcv - off; end
                  9: begin
                     tk = 1; tgt = pcv + off;
                     m_ras.push_back(16'((pcv + 1) % 65536));
                     if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                  end
                  10: begin
                     if (m_ras.size() > 0) begin
                        tk = 1; tgt = int'(m_ras.pop_back());
                     end else begin
                        m_fault = 1;
                     end
                  end
                  11: begin tk = 1; tgt = off; end
                  default: tk = 0;
               endcase
            end
            if (tk != 0) begin
               m_pc   = ((tgt % 65536) + 65536) % 65536;
               m_left = FLUSH_N;
               if (m_taken < 65535) m_taken = m_taken + 1;
            end else begin
               m_pc = (pcv + 1) % 65536;
            end
         end
      end
   endtask

   task automatic compare_all();
      check_eq("pc_o", 32'(pc_o), 32'(m_pc));
      check_eq("flushBack_o", 32'(flushBack_o), 32'(m_left > 0));
      check_eq("busy_o", 32'(busy_o), 32'(m_left > 0));
      check_eq("fault_o", 32'(fault_o), 32'(m_fault));
      check_eq("rasFull_o", 32'(rasFull_o), 32'(m_ras.size() == DEPTH));
      check_eq("rasEmpty_o", 32'(rasEmpty_o), 32'(m_ras.size() == 0));
`ifdef BRANCH_COUNT_EN
      check_eq("takenCount_o", 32'(takenCount_o), 32'(m_taken));
`endif
   endtask

   task automatic step(input bit rst, input bit en, input bit stall, input int op,
                       input int pop, input int sop, input int pc, input int stat);
      reset_i     = rst;
      enable_i    = en;
      isStalled_i = stall;
      opCode_i    = 7'(op);
      pOperand_i  = 16'(pop);
      sOperand_i  = 16'(sop);
      pc_i        = 16'(pc);
      opStat_i    = 2'(stat);
      @(posedge clock_i);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 16'h0200 + i, 0);
   endtask

   initial begin
      // Reset state
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 2, 9, 0, 7, 0);
      check_eq("rst_pc", 32'(pc_o), 32'h0);
      check_eq("rst_empty", 32'(rasEmpty_o), 32'h1);

      // Sequential fetch, then stall hold
      step(0, 0, 0, 0, 0, 0, 5, 0);
      check_eq("seq_pc", 32'(pc_o), 32'h6);
      step(0, 0, 1, 0, 0, 0, 9, 0);
      check_eq("stall_pc", 32'(pc_o), 32'h6);

      // Conditional branch: not taken, then taken, with an op ignored in FLUSH
      step(0, 1, 0, 1, 4, 0, 16'h10, 0);
      check_eq("bnz_nt_pc", 32'(pc_o), 32'h11);
      step(0, 1, 0, 1, 4, 1, 16'h10, 0);
      check_eq("bnz_t_pc", 32'(pc_o), 32'h14);
      check_eq("bnz_t_flush", 32'(flushBack_o), 32'h1);
      step(0, 1, 0, 2, 7, 0, 16'h100, 0);
      check_eq("flush_ign_pc", 32'(pc_o), 32'h14);
      check_eq("flush_cyc2", 32'(flushBack_o), 32'h1);
      step(0, 0, 0, 0, 0, 0, 16'h50, 0);
      check_eq("flush_end", 32'(flushBack_o), 32'h0);
      step(0, 0, 0, 0, 0, 0, 16'h50, 0);
      check_eq("resume_pc", 32'(pc_o), 32'h51);

      // Backward wrap-around
      step(0, 1, 0, 4, 5, 0, 16'h0002, 0);
      check_eq("wrap_pc", 32'(pc_o), 32'hFFFD);
      idle(FLUSH_N);

      // CALL then RET
      step(0, 1, 0, 9, 16'h10, 0, 16'h20, 0);
      check_eq("call_pc", 32'(pc_o), 32'h30);
      idle(FLUSH_N);
      step(0, 1, 0, 10, 0, 0, 16'h33, 0);
      check_eq("ret_pc", 32'(pc_o), 32'h21);
      check_eq("ret_empty", 32'(rasEmpty_o), 32'h1);
      idle(FLUSH_N);

      // Five CALLs overflow a 4-deep stack; four RETs return the newest four
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, 9, 1, 0, 16'h100 + i, 0);
         idle(FLUSH_N);
      end
      check_eq("ras_full", 32'(rasFull_o), 32'h1);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 0, 10, 0, 0, 16'h300, 0);
         check_eq("ras_pop", 32'(pc_o), 32'(16'h105 - i));
         idle(FLUSH_N);
      end
      check_eq("ras_drained", 32'(rasEmpty_o), 32'h1);

      // RET on empty stack
      step(0, 1, 0, 10, 0, 0, 16'h40, 0);
      check_eq("fault_pulse", 32'(fault_o), 32'h1);
      check_eq("fault_pc", 32'(pc_o), 32'h41);
      check_eq("fault_noflush", 32'(flushBack_o), 32'h0);
      step(0, 0, 0, 0, 0, 0, 16'h41, 0);
      check_eq("fault_clear", 32'(fault_o), 32'h0);

      // Reset during the first flush cycle aborts the sequence
      step(0, 1, 0, 11, 16'h1234, 0, 16'h60, 0);
      check_eq("jmpa_pc", 32'(pc_o), 32'h1234);
      step(1, 0, 0, 0, 0, 0, 16'h60, 0);
      check_eq("rst_flush_pc", 32'(pc_o), 32'h0);
      check_eq("rst_flush_busy", 32'(busy_o), 32'h0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int op;
         int sop;
         int pop;
         op  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(12, 127)) : int'($urandom_range(0, 11));
         if (op == 9 || op == 10) op = ($urandom_range(0, 1) == 0) ? 9 : 10;
         sop = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 65535));
         pop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 65535));
         step(($urandom_range(0, 249) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 7) == 0), op, pop, sop,
              int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
